// File: rtl/ofs_plat_axi_mem_pkg.sv
// ============================================================================
// ofs_plat_axi_mem_pkg
//
// Purpose : Shared types for the AXI memory platform blocks. This covers the
//           AXI response codes and the state encodings used by
//           ofs_plat_axi_mem_ram_responder.
// Ports   : none (package)
// Config  : none
// ============================================================================
package ofs_plat_axi_mem_pkg;

    // AXI BRESP/RRESP encoding
    typedef logic [1:0] t_axi_resp;

    localparam t_axi_resp AXI_RESP_OKAY   = 2'b00;
    localparam t_axi_resp AXI_RESP_SLVERR = 2'b10;

    // Write channel sequencing: address, data beats, then response
    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } t_axi_ram_wr_state;

    // Read channel sequencing: address, then beats until the last one
    typedef enum logic {
        R_IDLE,
        R_BURST
    } t_axi_ram_rd_state;

endpackage : ofs_plat_axi_mem_pkg

// File: rtl/ofs_plat_axi_mem_ram_burst_ctr.sv
// ============================================================================
// ofs_plat_axi_mem_ram_burst_ctr
//
// Purpose : Burst address walker for one AXI channel of the RAM responder.
//           load_i captures the starting word index and the burst length, and
//           advance_i steps to the next beat. The current RAM word wraps
//           modulo MEM_DEPTH. out_of_range_o flags a beat whose unwrapped
//           index is at or beyond MEM_DEPTH.
//
// Ports   : clk, reset_n          clock, synchronous active-low reset
//           load_i                capture index_i / len_i, beat count := 0
//           index_i [IDX_WIDTH]   starting word index (full address width)
//           len_i   [LEN_WIDTH]   AXI len (beats - 1)
//           advance_i             step to the next beat
//           cur_index_o           RAM word for the current beat (wrapped)
//           is_last_o             current beat is beat len
//           out_of_range_o        unwrapped index of current beat >= MEM_DEPTH
// Config  : none (range-check use is decided by the parent)
//
// MEM_DEPTH must be a power of two. IDX_WIDTH must be >= $clog2(MEM_DEPTH).
// ============================================================================
module ofs_plat_axi_mem_ram_burst_ctr #(
    parameter int IDX_WIDTH = 13,
    parameter int LEN_WIDTH = 8,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         load_i,
    input  logic [IDX_WIDTH-1:0]         index_i,
    input  logic [LEN_WIDTH-1:0]         len_i,
    input  logic                         advance_i,
    output logic [$clog2(MEM_DEPTH)-1:0] cur_index_o,
    output logic                         is_last_o,
    output logic                         out_of_range_o
);

    localparam int DEPTH_BITS = $clog2(MEM_DEPTH);
    // One spare bit so base + beat never loses its carry
    localparam int SUM_W = ((IDX_WIDTH > LEN_WIDTH) ? IDX_WIDTH : LEN_WIDTH) + 1;

    logic [IDX_WIDTH-1:0] base_q, base_d;
    logic [LEN_WIDTH-1:0] len_q,  len_d;
    logic [LEN_WIDTH-1:0] beat_q, beat_d;
    logic [SUM_W-1:0]     sum;

    always_comb begin
        // NOTE: every variable assigned here gets a default first. A path
        // that leaves one unassigned would make it hold its value, which
        // infers a latch.
        base_d = base_q;
        len_d  = len_q;
        beat_d = beat_q;
        if (load_i) begin
            base_d = index_i;
            len_d  = len_i;
            beat_d = '0;
        end else if (advance_i) begin
            beat_d = beat_q + LEN_WIDTH'(1);
        end
    end

    // NOTE: state registers use non-blocking (<=) so all flops update
    // together at the edge. Blocking assignments here would let one
    // register see another's new value within the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            base_q <= '0;
            len_q  <= '0;
            beat_q <= '0;
        end else begin
            base_q <= base_d;
            len_q  <= len_d;
            beat_q <= beat_d;
        end
    end

    assign sum            = SUM_W'(base_q) + SUM_W'(beat_q);
    assign cur_index_o    = sum[DEPTH_BITS-1:0];
    assign out_of_range_o = |sum[SUM_W-1:DEPTH_BITS];
    assign is_last_o      = (beat_q == len_q);

endmodule : ofs_plat_axi_mem_ram_burst_ctr

// File: rtl/ofs_plat_axi_mem_ram_responder.sv
// ============================================================================
// ofs_plat_axi_mem_ram_responder
//
// Purpose : AXI slave endpoint backed by an internal word-addressed RAM.
//           It serves AW/W/B and AR/R concurrently. B returns the AW id/user,
//           and R returns the AR id/user. Bursts are always treated as INCR
//           at full data width (size/burst/wlast are not consumed). Used as
//           an on-chip scratchpad and as a simulation endpoint for AFU
//           traffic.
//
// Ports   : clk, reset_n                  clock, synchronous active-low reset
//           axi_aw{valid,addr,len,id,user}_i, axi_awready_o   write address
//           axi_w{valid,data,strb}_i, axi_wready_o             write data
//           axi_b{valid,id,resp,user}_o, axi_bready_i          write response
//           axi_ar{valid,addr,len,id,user}_i, axi_arready_o   read address
//           axi_r{valid,data,resp,last,id,user}_o, axi_rready_i read data
//
// Config  : OFS_PLAT_AXI_MEM_RAM_RANGE_CHECK_EN
//             defined   - beats whose unwrapped word index >= MEM_DEPTH are
//                         errors: write beats are dropped and B reports
//                         SLVERR; read beats return zero data with SLVERR.
//             undefined - indices wrap modulo MEM_DEPTH, all responses OKAY.
//
// RAM contents are not cleared by reset. A reset mid-burst abandons the
// burst without any response. DATA_WIDTH must be a multiple of 8 and at
// least 16.
// ============================================================================
module ofs_plat_axi_mem_ram_responder
    import ofs_plat_axi_mem_pkg::*;
#(
    parameter int MEM_DEPTH       = 1024,
    parameter int ADDR_WIDTH      = 48,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 8,
    parameter int RID_WIDTH       = 8,
    parameter int WID_WIDTH       = 8,
    parameter int USER_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,

    input  logic                      axi_awvalid_i,
    output logic                      axi_awready_o,
    input  logic [ADDR_WIDTH-1:0]     axi_awaddr_i,
    input  logic [BURST_CNT_WIDTH-1:0] axi_awlen_i,
    input  logic [WID_WIDTH-1:0]      axi_awid_i,
    input  logic [USER_WIDTH-1:0]     axi_awuser_i,

    input  logic                      axi_wvalid_i,
    output logic                      axi_wready_o,
    input  logic [DATA_WIDTH-1:0]     axi_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   axi_wstrb_i,

    output logic                      axi_bvalid_o,
    input  logic                      axi_bready_i,
    output logic [WID_WIDTH-1:0]      axi_bid_o,
    output logic [1:0]                axi_bresp_o,
    output logic [USER_WIDTH-1:0]     axi_buser_o,

    input  logic                      axi_arvalid_i,
    output logic                      axi_arready_o,
    input  logic [ADDR_WIDTH-1:0]     axi_araddr_i,
    input  logic [BURST_CNT_WIDTH-1:0] axi_arlen_i,
    input  logic [RID_WIDTH-1:0]      axi_arid_i,
    input  logic [USER_WIDTH-1:0]     axi_aruser_i,

    output logic                      axi_rvalid_o,
    input  logic                      axi_rready_i,
    output logic [DATA_WIDTH-1:0]     axi_rdata_o,
    output logic [1:0]                axi_rresp_o,
    output logic                      axi_rlast_o,
    output logic [RID_WIDTH-1:0]      axi_rid_o,
    output logic [USER_WIDTH-1:0]     axi_ruser_o
);

    localparam int DATA_N_BYTES = DATA_WIDTH / 8;
    localparam int ADDR_OFS     = $clog2(DATA_N_BYTES);
    localparam int IDX_WIDTH    = ADDR_WIDTH - ADDR_OFS;
    localparam int DEPTH_BITS   = $clog2(MEM_DEPTH);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // ------------------------------------------------------------------
    // Handshakes and burst walkers
    // ------------------------------------------------------------------
    t_axi_ram_wr_state wr_state_q;
    t_axi_ram_rd_state rd_state_q;

    logic awready_q, wready_q, bvalid_q;
    logic arready_q, rvalid_q;

    logic aw_fire, w_fire, ar_fire, r_fire;
    logic [DEPTH_BITS-1:0] wr_idx, rd_idx;
    logic wr_last, rd_last, wr_oor, rd_oor;
    logic wr_beat_err, rd_beat_err;

    assign aw_fire = axi_awvalid_i & awready_q;
    assign w_fire  = axi_wvalid_i  & wready_q;
    assign ar_fire = axi_arvalid_i & arready_q;
    assign r_fire  = rvalid_q      & axi_rready_i;

    ofs_plat_axi_mem_ram_burst_ctr #(
        .IDX_WIDTH (IDX_WIDTH),
        .LEN_WIDTH (BURST_CNT_WIDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_wr_ctr (
        .clk            (clk),
        .reset_n        (reset_n),
        .load_i         (aw_fire),
        .index_i        (axi_awaddr_i[ADDR_WIDTH-1:ADDR_OFS]),
        .len_i          (axi_awlen_i),
        .advance_i      (w_fire),
        .cur_index_o    (wr_idx),
        .is_last_o      (wr_last),
        .out_of_range_o (wr_oor)
    );

    ofs_plat_axi_mem_ram_burst_ctr #(
        .IDX_WIDTH (IDX_WIDTH),
        .LEN_WIDTH (BURST_CNT_WIDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_rd_ctr (
        .clk            (clk),
        .reset_n        (reset_n),
        .load_i         (ar_fire),
        .index_i        (axi_araddr_i[ADDR_WIDTH-1:ADDR_OFS]),
        .len_i          (axi_arlen_i),
        .advance_i      (r_fire),
        .cur_index_o    (rd_idx),
        .is_last_o      (rd_last),
        .out_of_range_o (rd_oor)
    );

`ifdef OFS_PLAT_AXI_MEM_RAM_RANGE_CHECK_EN
    assign wr_beat_err = wr_oor;
    assign rd_beat_err = rd_oor;

    // Byte-offset address bits are intentionally ignored
    logic unused_ok;
    assign unused_ok = &{1'b0, axi_awaddr_i, axi_araddr_i};
`else
    assign wr_beat_err = 1'b0;
    assign rd_beat_err = 1'b0;

    // Without range checking the wrapped index is all that matters
    logic unused_ok;
    assign unused_ok = &{1'b0, axi_awaddr_i, axi_araddr_i, wr_oor, rd_oor};
`endif

    // ------------------------------------------------------------------
    // RAM write port. Gated by reset_n so a beat coinciding with reset
    // is abandoned along with the rest of its burst.
    // ------------------------------------------------------------------
    logic ram_we;
    assign ram_we = w_fire & reset_n & ~wr_beat_err;

    // NOTE: the RAM array has no reset branch. Clearing it would turn the
    // storage into a large bank of resettable flops rather than a RAM, and
    // its contents are intentionally preserved across reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < DATA_N_BYTES; b++) begin
                if (axi_wstrb_i[b]) begin
                    mem_q[wr_idx][b*8 +: 8] <= axi_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    logic [WID_WIDTH-1:0]  bid_q;
    logic [USER_WIDTH-1:0] buser_q;
    t_axi_resp             bresp_q;
    logic                  wr_err_q;   // some beat of this burst was dropped

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b1;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
            buser_q    <= '0;
            bresp_q    <= AXI_RESP_OKAY;
            wr_err_q   <= 1'b0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (aw_fire) begin
                        bid_q      <= axi_awid_i;
                        buser_q    <= axi_awuser_i;
                        wr_err_q   <= 1'b0;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                        wr_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (wr_beat_err) wr_err_q <= 1'b1;
                        // Burst length comes from AW len; wlast is not used
                        if (wr_last) begin
                            wready_q   <= 1'b0;
                            bvalid_q   <= 1'b1;
                            bresp_q    <= (wr_err_q | wr_beat_err) ? AXI_RESP_SLVERR
                                                                   : AXI_RESP_OKAY;
                            wr_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_bready_i) begin
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: begin
                    wr_state_q <= W_IDLE;
                    awready_q  <= 1'b1;
                    wready_q   <= 1'b0;
                    bvalid_q   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    logic [RID_WIDTH-1:0]  rid_q;
    logic [USER_WIDTH-1:0] ruser_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rid_q      <= '0;
            ruser_q    <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (ar_fire) begin
                        rid_q      <= axi_arid_i;
                        ruser_q    <= axi_aruser_i;
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rd_state_q <= R_BURST;
                    end
                end
                R_BURST: begin
                    if (r_fire && rd_last) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: begin
                    rd_state_q <= R_IDLE;
                    arready_q  <= 1'b1;
                    rvalid_q   <= 1'b0;
                end
            endcase
        end
    end

    // Read data is an asynchronous RAM read. A write to the same word
    // lands at the clock edge, so a same-cycle read still returns the old
    // data. The payload is forced to zero whenever rvalid is low.
    always_comb begin
        axi_rdata_o = '0;
        axi_rresp_o = AXI_RESP_OKAY;
        if (rvalid_q) begin
            if (rd_beat_err) axi_rresp_o = AXI_RESP_SLVERR;
            else             axi_rdata_o = mem_q[rd_idx];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign axi_awready_o = awready_q;
    assign axi_wready_o  = wready_q;
    assign axi_bvalid_o  = bvalid_q;
    assign axi_bid_o     = bid_q;
    assign axi_buser_o   = buser_q;
    assign axi_bresp_o   = bresp_q;

    assign axi_arready_o = arready_q;
    assign axi_rvalid_o  = rvalid_q;
    assign axi_rlast_o   = rvalid_q & rd_last;
    assign axi_rid_o     = rid_q;
    assign axi_ruser_o   = ruser_q;

endmodule : ofs_plat_axi_mem_ram_responder

// File: tb/tb_ofs_plat_axi_mem_ram_responder.sv
// ============================================================================
// tb_ofs_plat_axi_mem_ram_responder
//
// Directed bench for the AXI RAM responder. It uses a 64-word x 64-bit RAM
// with a 16-bit byte address, so word N lives at byte address N*8.
// Behaviour of the last-word burst follows OFS_PLAT_AXI_MEM_RAM_RANGE_CHECK_EN.
// ============================================================================
module tb_ofs_plat_axi_mem_ram_responder;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 64;
    localparam int LEN_W   = 8;
    localparam int RID_W   = 4;
    localparam int WID_W   = 4;
    localparam int USER_W  = 4;
    localparam int DEPTH   = 64;
    localparam int TIMEOUT = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic              axi_awvalid_i, axi_awready_o;
    logic [ADDR_W-1:0] axi_awaddr_i;
    logic [LEN_W-1:0]  axi_awlen_i;
    logic [WID_W-1:0]  axi_awid_i;
    logic [USER_W-1:0] axi_awuser_i;
    logic              axi_wvalid_i, axi_wready_o;
    logic [DATA_W-1:0] axi_wdata_i;
    logic [7:0]        axi_wstrb_i;
    logic              axi_bvalid_o, axi_bready_i;
    logic [WID_W-1:0]  axi_bid_o;
    logic [1:0]        axi_bresp_o;
    logic [USER_W-1:0] axi_buser_o;
    logic              axi_arvalid_i, axi_arready_o;
    logic [ADDR_W-1:0] axi_araddr_i;
    logic [LEN_W-1:0]  axi_arlen_i;
    logic [RID_W-1:0]  axi_arid_i;
    logic [USER_W-1:0] axi_aruser_i;
    logic              axi_rvalid_o, axi_rready_i;
    logic [DATA_W-1:0] axi_rdata_o;
    logic [1:0]        axi_rresp_o;
    logic              axi_rlast_o;
    logic [RID_W-1:0]  axi_rid_o;
    logic [USER_W-1:0] axi_ruser_o;

    int n_checks = 0;
    int n_errors = 0;

    ofs_plat_axi_mem_ram_responder #(
        .MEM_DEPTH       (DEPTH),
        .ADDR_WIDTH      (ADDR_W),
        .DATA_WIDTH      (DATA_W),
        .BURST_CNT_WIDTH (LEN_W),
        .RID_WIDTH       (RID_W),
        .WID_WIDTH       (WID_W),
        .USER_WIDTH      (USER_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .axi_awvalid_i (axi_awvalid_i),
        .axi_awready_o (axi_awready_o),
        .axi_awaddr_i  (axi_awaddr_i),
        .axi_awlen_i   (axi_awlen_i),
        .axi_awid_i    (axi_awid_i),
        .axi_awuser_i  (axi_awuser_i),
        .axi_wvalid_i  (axi_wvalid_i),
        .axi_wready_o  (axi_wready_o),
        .axi_wdata_i   (axi_wdata_i),
        .axi_wstrb_i   (axi_wstrb_i),
        .axi_bvalid_o  (axi_bvalid_o),
        .axi_bready_i  (axi_bready_i),
        .axi_bid_o     (axi_bid_o),
        .axi_bresp_o   (axi_bresp_o),
        .axi_buser_o   (axi_buser_o),
        .axi_arvalid_i (axi_arvalid_i),
        .axi_arready_o (axi_arready_o),
        .axi_araddr_i  (axi_araddr_i),
        .axi_arlen_i   (axi_arlen_i),
        .axi_arid_i    (axi_arid_i),
        .axi_aruser_i  (axi_aruser_i),
        .axi_rvalid_o  (axi_rvalid_o),
        .axi_rready_i  (axi_rready_i),
        .axi_rdata_o   (axi_rdata_o),
        .axi_rresp_o   (axi_rresp_o),
        .axi_rlast_o   (axi_rlast_o),
        .axi_rid_o     (axi_rid_o),
        .axi_ruser_o   (axi_ruser_o)
    );

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; outputs are sampled there
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Burst data pattern for the first write
    function automatic logic [63:0] dpat(input int i);
        return 64'h0123_4567_89AB_CD00 + 64'(i);
    endfunction

    task automatic send_aw(input logic [15:0] addr, input logic [7:0] len,
                           input logic [3:0] id, input logic [3:0] user);
        int n;
        n = 0;
        axi_awaddr_i  = addr;
        axi_awlen_i   = len;
        axi_awid_i    = id;
        axi_awuser_i  = user;
        axi_awvalid_i = 1'b1;
        while (axi_awready_o !== 1'b1 && n < TIMEOUT) begin tick(); n++; end
        check("awready", 64'(axi_awready_o), 64'd1);
        tick();
        axi_awvalid_i = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] data, input logic [7:0] strb);
        int n;
        n = 0;
        axi_wdata_i  = data;
        axi_wstrb_i  = strb;
        axi_wvalid_i = 1'b1;
        while (axi_wready_o !== 1'b1 && n < TIMEOUT) begin tick(); n++; end
        check("wready", 64'(axi_wready_o), 64'd1);
        tick();
        axi_wvalid_i = 1'b0;
    endtask

    task automatic send_ar(input logic [15:0] addr, input logic [7:0] len,
                           input logic [3:0] id, input logic [3:0] user);
        int n;
        n = 0;
        axi_araddr_i  = addr;
        axi_arlen_i   = len;
        axi_arid_i    = id;
        axi_aruser_i  = user;
        axi_arvalid_i = 1'b1;
        while (axi_arready_o !== 1'b1 && n < TIMEOUT) begin tick(); n++; end
        check("arready", 64'(axi_arready_o), 64'd1);
        tick();
        axi_arvalid_i = 1'b0;
    endtask

    task automatic expect_b(input string tag, input logic [3:0] id,
                            input logic [3:0] user, input logic [1:0] resp);
        int n;
        n = 0;
        while (axi_bvalid_o !== 1'b1 && n < TIMEOUT) begin tick(); n++; end
        check({tag, "_bvalid"}, 64'(axi_bvalid_o), 64'd1);
        check({tag, "_bid"},    64'(axi_bid_o),    64'(id));
        check({tag, "_buser"},  64'(axi_buser_o),  64'(user));
        check({tag, "_bresp"},  64'(axi_bresp_o),  64'(resp));
        axi_bready_i = 1'b1;
        tick();
        axi_bready_i = 1'b0;
    endtask

    task automatic expect_r(input string tag, input logic [63:0] data, input logic last,
                            input logic [1:0] resp, input logic [3:0] id, input logic [3:0] user);
        int n;
        n = 0;
        while (axi_rvalid_o !== 1'b1 && n < TIMEOUT) begin tick(); n++; end
        check({tag, "_rvalid"}, 64'(axi_rvalid_o), 64'd1);
        check({tag, "_rdata"},  axi_rdata_o,       data);
        check({tag, "_rlast"},  64'(axi_rlast_o),  64'(last));
        check({tag, "_rresp"},  64'(axi_rresp_o),  64'(resp));
        check({tag, "_rid"},    64'(axi_rid_o),    64'(id));
        check({tag, "_ruser"},  64'(axi_ruser_o),  64'(user));
        axi_rready_i = 1'b1;
        tick();
        axi_rready_i = 1'b0;
    endtask

    // Hard stop if the directed sequence wedges somewhere unexpected
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d",
                 n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        reset_n       = 1'b0;
        axi_awvalid_i = 1'b0; axi_awaddr_i = '0; axi_awlen_i = '0;
        axi_awid_i    = '0;   axi_awuser_i = '0;
        axi_wvalid_i  = 1'b0; axi_wdata_i  = '0; axi_wstrb_i = '0;
        axi_bready_i  = 1'b0;
        axi_arvalid_i = 1'b0; axi_araddr_i = '0; axi_arlen_i = '0;
        axi_arid_i    = '0;   axi_aruser_i = '0;
        axi_rready_i  = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_awready", 64'(axi_awready_o), 64'd1);
        check("rst_arready", 64'(axi_arready_o), 64'd1);
        check("rst_wready",  64'(axi_wready_o),  64'd0);
        check("rst_bvalid",  64'(axi_bvalid_o),  64'd0);
        check("rst_rvalid",  64'(axi_rvalid_o),  64'd0);
        check("rst_bpay",    64'({axi_bid_o, axi_buser_o, axi_bresp_o}), 64'd0);
        check("rst_rpay",    64'({axi_rid_o, axi_ruser_o, axi_rresp_o, axi_rlast_o}), 64'd0);
        check("rst_rdata",   axi_rdata_o, 64'd0);
        reset_n = 1'b1;
        tick();

        // 1. Four-beat write to 0x40 (words 8..11), then read it back
        send_aw(16'h0040, 8'd3, 4'd2, 4'd5);
        for (int i = 0; i < 4; i++) send_w(dpat(i), 8'hFF);
        check("w1_wready_after", 64'(axi_wready_o), 64'd0);
        // bvalid must hold while bready is low
        tick(); tick();
        check("w1_bvalid_hold", 64'(axi_bvalid_o), 64'd1);
        expect_b("w1", 4'd2, 4'd5, 2'b00);
        check("w1_awready_back", 64'(axi_awready_o), 64'd1);

        send_ar(16'h0040, 8'd3, 4'd1, 4'd7);
        // First beat is valid in the cycle right after the AR handshake
        check("r1_latency", 64'(axi_rvalid_o), 64'd1);
        check("r1_arready_busy", 64'(axi_arready_o), 64'd0);
        for (int i = 0; i < 4; i++) expect_r("r1", dpat(i), (i == 3), 2'b00, 4'd1, 4'd7);
        check("r1_done", 64'(axi_rvalid_o), 64'd0);

        // 2. Partial strobe: only the low four bytes change
        send_aw(16'h00A0, 8'd0, 4'd3, 4'd0);
        send_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        expect_b("w2a", 4'd3, 4'd0, 2'b00);
        send_aw(16'h00A0, 8'd0, 4'd4, 4'd0);
        send_w(64'h1122_3344_5566_7788, 8'h0F);
        expect_b("w2b", 4'd4, 4'd0, 2'b00);
        send_ar(16'h00A0, 8'd0, 4'd2, 4'd3);
        expect_r("r2", 64'hFFFF_FFFF_5566_7788, 1'b1, 2'b00, 4'd2, 4'd3);

        // 3. rready low for five cycles in the middle of a burst
        send_ar(16'h0040, 8'd3, 4'd6, 4'd9);
        expect_r("r3b0", dpat(0), 1'b0, 2'b00, 4'd6, 4'd9);
        for (int c = 0; c < 5; c++) begin
            check("r3_hold_rvalid", 64'(axi_rvalid_o), 64'd1);
            check("r3_hold_rdata",  axi_rdata_o,       dpat(1));
            check("r3_hold_rlast",  64'(axi_rlast_o),  64'd0);
            tick();
        end
        for (int i = 1; i < 4; i++) expect_r("r3", dpat(i), (i == 3), 2'b00, 4'd6, 4'd9);

        // 4. W beat presented three cycles before AW (word 30)
        axi_wdata_i  = 64'hDEAD_BEEF_0BAD_F00D;
        axi_wstrb_i  = 8'hFF;
        axi_wvalid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("w4_early_wready", 64'(axi_wready_o), 64'd0);
            tick();
        end
        send_aw(16'h00F0, 8'd0, 4'd8, 4'd1);
        send_w(64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
        expect_b("w4", 4'd8, 4'd1, 2'b00);
        send_ar(16'h00F0, 8'd0, 4'd5, 4'd5);
        expect_r("r4", 64'hDEAD_BEEF_0BAD_F00D, 1'b1, 2'b00, 4'd5, 4'd5);

        // 5. Two-beat burst starting at the last word (63, byte addr 0x1F8)
        send_aw(16'h0000, 8'd0, 4'd1, 4'd1);
        send_w(64'h5A5A_5A5A_5A5A_5A5A, 8'hFF);
        expect_b("w5pre", 4'd1, 4'd1, 2'b00);
        send_aw(16'h01F8, 8'd1, 4'd9, 4'd2);
        send_w(64'h6300_0000_0000_0063, 8'hFF);
        send_w(64'h0000_0000_0000_0BB1, 8'hFF);
`ifdef OFS_PLAT_AXI_MEM_RAM_RANGE_CHECK_EN
        expect_b("w5", 4'd9, 4'd2, 2'b10);
        send_ar(16'h01F8, 8'd1, 4'd3, 4'd4);
        expect_r("r5b0", 64'h6300_0000_0000_0063, 1'b0, 2'b00, 4'd3, 4'd4);
        expect_r("r5b1", 64'h0,                   1'b1, 2'b10, 4'd3, 4'd4);
        send_ar(16'h0000, 8'd0, 4'd3, 4'd4);
        expect_r("r5w0", 64'h5A5A_5A5A_5A5A_5A5A, 1'b1, 2'b00, 4'd3, 4'd4);
`else
        expect_b("w5", 4'd9, 4'd2, 2'b00);
        send_ar(16'h01F8, 8'd1, 4'd3, 4'd4);
        expect_r("r5b0", 64'h6300_0000_0000_0063, 1'b0, 2'b00, 4'd3, 4'd4);
        expect_r("r5b1", 64'h0000_0000_0000_0BB1, 1'b1, 2'b00, 4'd3, 4'd4);
        send_ar(16'h0000, 8'd0, 4'd3, 4'd4);
        expect_r("r5w0", 64'h0000_0000_0000_0BB1, 1'b1, 2'b00, 4'd3, 4'd4);
`endif

        // 6. Reset during beat 2 of a four-beat read
        send_ar(16'h0040, 8'd3, 4'd3, 4'd1);
        expect_r("r6b0", dpat(0), 1'b0, 2'b00, 4'd3, 4'd1);
        expect_r("r6b1", dpat(1), 1'b0, 2'b00, 4'd3, 4'd1);
        check("r6b2_shown", axi_rdata_o, dpat(2));
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("r6_rst_rvalid",  64'(axi_rvalid_o),  64'd0);
        check("r6_rst_arready", 64'(axi_arready_o), 64'd1);
        check("r6_rst_rdata",   axi_rdata_o,        64'd0);
        tick();
        check("r6_no_resume", 64'(axi_rvalid_o), 64'd0);
        // RAM survives reset and a fresh AR is served normally
        send_ar(16'h0048, 8'd0, 4'd4, 4'd2);
        expect_r("r6_fresh", dpat(1), 1'b1, 2'b00, 4'd4, 4'd2);
        check("r6_idle", 64'(axi_rvalid_o), 64'd0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ofs_plat_axi_mem_ram_responder
